spi_slave_rx_tx: RTL and testbench
==================================

# spi_slave_rx_tx

SPI responder for the far end of the bus driven by the team's SPI master. It oversamples `sclk`/`cs_n`/`mosi` in the local `clk` domain, shifts in one frame of `DATA_W` bits per chip-select window, and returns a pre-loaded byte on `miso`. A valid/ready parallel interface hands TX bytes in and received bytes out to the local controller.

## Interface
- `DATA_W`, 8, frame length in bits (2..16)
- `clk`  in  1  system clock; all logic synchronous to it
- `reset_n`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock from master (async); idles high
- `cs_n`  in  1  chip select from master (async), active low
- `mosi`  in  1  serial data from master (async)
- `miso`  out  1  serial data to master
- `miso_oe`  out  1  high while selected (external tristate enable)
- `tx_data`  in  DATA_W  byte to return in next frame
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  TX holding register empty
- `rx_data`  out  DATA_W  last completed received frame
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated
- `tx_underrun`  out  1  one-cycle pulse, frame started with empty TX holding register
- `busy`  out  1  high in SHIFT state

## Operation
- Input sync: `sclk`, `cs_n`, `mosi` each pass a 2-flop synchronizer (reset values 1, 1, 0); a third flop on `sclk`/`cs_n` provides edge detect.
- States: IDLE, SHIFT.
- IDLE -> SHIFT on synchronized `cs_n` falling edge: load TX shift register from holding register (or all-zeros if empty, pulsing `tx_underrun`), mark holding register empty, `bit_cnt` = 0, drive first TX bit on `miso`.
- SHIFT: on synchronized `sclk` rising edge sample `mosi` into RX shift register, `bit_cnt`++. On `sclk` falling edge shift TX register, present next bit on `miso`.
- Frame complete when `bit_cnt` reaches `DATA_W` on a rising edge: `rx_data` <= assembled word, `rx_valid` pulses, `bit_cnt` -> 0. If `cs_n` stays low, next `sclk` falling edge reloads TX shift register from holding register (same underrun rule) and a new frame begins; state remains SHIFT.
- Bit order: LSB first (bit 0 first on both lines), matching the master's `{miso, data[7:1]}` shift.
- SHIFT -> IDLE on synchronized `cs_n` rising edge at any point; a partial frame is discarded (no `rx_valid`, `rx_data` unchanged), `bit_cnt` cleared.
- TX holding register: accepts `tx_data` when `tx_valid && tx_ready`; `tx_ready` = empty. Load and frame-start in same cycle with register empty: frame starts with zeros plus `tx_underrun`, written byte stays in register for next frame.
- `miso` = 0 and `miso_oe` = 0 in IDLE.

## Timing
- Reset values: `miso` 0, `miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `tx_underrun` 0, `busy` 0, state IDLE.
- `sclk` high and low phases must each be >= 4 `clk` cycles; `cs_n` setup to first `sclk` falling edge >= 4 `clk` cycles.
- `rx_valid` asserts 3 `clk` cycles after the final `sclk` rising edge at the pin.
- `miso` changes 3 `clk` cycles after each `sclk` falling edge (and after `cs_n` falling edge for bit 0).
- Reset mid-frame: immediate return to reset values; frame lost.

## Configuration
- `SPI_SLAVE_MSB_FIRST_EN`: when defined, both RX and TX shift MSB first (bit `DATA_W-1` first). When undefined, LSB first as above. No other behaviour changes.

## Test plan
- Write `tx_data`=0xA5, master sends 0x3C LSB-first with 18-clk `sclk` period -> `rx_data`=0x3C with one `rx_valid` pulse; master captures 0xA5; `tx_ready` returns 1 at frame start.
- No TX write, one frame 0xFF -> `tx_underrun` pulses once at `cs_n` fall, `miso` returns 0x00, `rx_data`=0xFF.
- `cs_n` held low for two frames 0x12, 0x34 with TX 0x55 then 0xAA loaded between -> two `rx_valid` pulses, `miso` returns 0x55 then 0xAA.
- `cs_n` deasserted after 5 bits -> no `rx_valid`, `rx_data` keeps prior value, `busy` drops within 3 clk; next full frame 0x81 received correctly.
- `reset_n` pulsed low mid-frame -> all outputs at reset values on the same cycle; following frame 0x7E received correctly.
- Build with `SPI_SLAVE_MSB_FIRST_EN`, master sends 0x01 MSB-first -> `rx_data`=0x01; TX 0x80 appears as first bit 1 on `miso`.

Source files
------------

// File: rtl/spi_slave_rx_tx_if.sv
`default_nettype none
// ============================================================================
// Interface : spi_slave_rx_tx_if
// Purpose   : Parallel valid/ready bus between the local controller and the
//             SPI responder. TX words flow controller -> responder, received
//             words flow responder -> controller.
// Signals   : tx_data  [DATA_W]  word to return in the next SPI frame
//             tx_valid           tx_data valid
//             tx_ready           responder TX holding register empty
//             rx_data  [DATA_W]  last completed received frame
//             rx_valid           one-cycle pulse, rx_data updated
// Modports  : master - local controller side
//             slave  - SPI responder side
// Revision  : 1.0 - initial release
// ============================================================================
interface spi_slave_rx_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module    : spi_slave_rx_tx
// Purpose   : SPI responder (sclk idles high, data changes on falling edge,
//             sampled on rising edge). Oversamples sclk/cs_n/mosi in the clk
//             domain, receives one DATA_W-bit frame per frame window and
//             returns a pre-loaded word on miso.
// Ports     : clk            system clock
//             reset_n        asynchronous active-low reset
//             sclk_i         SPI clock from master (async, idles high)
//             cs_n_i         chip select from master (async, active low)
//             mosi_i         serial data from master (async)
//             miso_o         serial data to master (0 when idle)
//             miso_oe_o      external tristate enable, high while selected
//             tx_underrun_o  pulse: frame started with empty TX holding reg
//             busy_o         high while in SHIFT state
//             bus_if         valid/ready TX/RX bus (slave modport)
// Config    : SPI_SLAVE_MSB_FIRST_EN - when defined, RX and TX shift MSB
//             first; otherwise LSB first.
// Note      : DATA_W must match the DATA_W of the connected bus_if.
// Revision  : 1.0 - initial release
// ============================================================================
module spi_slave_rx_tx #(
  parameter int DATA_W = 8
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        sclk_i,
  input  wire logic        cs_n_i,
  input  wire logic        mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  output logic             tx_underrun_o,
  output logic             busy_o,
  spi_slave_rx_tx_if.slave bus_if
);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_sync_q;
  logic [2:0]        cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  // Set when a frame completes with cs_n still low: the next sclk falling
  // edge then presents bit 0 of a freshly loaded word instead of shifting.
  logic              reload_q, reload_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
  logic [DATA_W-1:0] w_rx_next, w_tx_next, w_load_word;
  logic              w_tx_bit;
  logic              w_take;

  // Index [1] is the synchronized level, [2] the previous one for edge detect.
  assign w_sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign w_sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign w_cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign w_cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign w_mosi      = mosi_sync_q[1];

`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign w_rx_next = {rx_shift_q[DATA_W-2:0], w_mosi};
  assign w_tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
  assign w_tx_bit  = tx_shift_q[DATA_W-1];
`else
  assign w_rx_next = {w_mosi, rx_shift_q[DATA_W-1:1]};
  assign w_tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
  assign w_tx_bit  = tx_shift_q[0];
`endif

  // An empty holding register sends zeros for the whole frame.
  assign w_load_word = hold_full_q ? hold_q : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= 3'b111;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      reload_q    <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      reload_q    <= reload_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    reload_d    = reload_q;
    bit_cnt_d   = bit_cnt_q;
    w_take      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_cs_fall) begin
          state_d    = ST_SHIFT;
          w_take     = 1'b1;
          tx_shift_d = w_load_word;
          underrun_d = ~hold_full_q;
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          // Partial frame is dropped; rx_data keeps its last full frame.
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (w_sclk_rise) begin
          rx_shift_d = w_rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = w_rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else if (w_sclk_fall) begin
          if (reload_q) begin
            w_take     = 1'b1;
            tx_shift_d = w_load_word;
            underrun_d = ~hold_full_q;
            reload_d   = 1'b0;
          end else if (bit_cnt_q != '0) begin
            // The leading falling edge of the first frame keeps bit 0,
            // which was already presented at the cs_n falling edge.
            tx_shift_d = w_tx_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write accepted in the same cycle as a take of an empty register
    // survives and is used by the following frame.
    if (hold_full_q) begin
      if (w_take) hold_full_d = 1'b0;
    end else if (bus_if.tx_valid) begin
      hold_full_d = 1'b1;
      hold_d      = bus_if.tx_data;
    end
  end

  assign miso_o          = (state_q == ST_SHIFT) & w_tx_bit;
  assign miso_oe_o       = (state_q == ST_SHIFT);
  assign busy_o          = (state_q == ST_SHIFT);
  assign tx_underrun_o   = underrun_q;
  assign bus_if.tx_ready = ~hold_full_q;
  assign bus_if.rx_data  = rx_data_q;
  assign bus_if.rx_valid = rx_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_spi_slave_rx_tx
// Purpose   : Self-checking bench for spi_slave_rx_tx. Acts as the SPI master
//             (sclk idles high, 18-clk period) and as the local controller.
//             Received words are scoreboarded through a queue.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx_tx;
  localparam int DATA_W = 8;
  localparam int HALF   = 9;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sclk    = 1'b1;
  logic cs_n    = 1'b1;
  logic mosi    = 1'b0;
  logic miso, miso_oe, tx_underrun, busy;

  spi_slave_rx_tx_if #(.DATA_W(DATA_W)) bus_if ();

  spi_slave_rx_tx #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclk_i       (sclk),
    .cs_n_i       (cs_n),
    .mosi_i       (mosi),
    .miso_o       (miso),
    .miso_oe_o    (miso_oe),
    .tx_underrun_o(tx_underrun),
    .busy_o       (busy),
    .bus_if       (bus_if)
  );

  always #5 clk = ~clk;

  int n_total    = 0;
  int n_bad      = 0;
  int n_underrun = 0;
  int n_rxv      = 0;
  logic [DATA_W-1:0] rx_exp_q[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_MSB_FIRST_EN
    return DATA_W - 1 - i;
`else
    return i;
`endif
  endfunction

  // Scoreboard consumer and pulse counters, sampled away from posedge.
  always @(negedge clk) begin
    if (reset_n && tx_underrun) n_underrun++;
    if (reset_n && bus_if.rx_valid) begin
      n_rxv++;
      check_value("rx_expected_pending", rx_exp_q.size() > 0, 1);
      if (rx_exp_q.size() > 0) check_value("rx_data", bus_if.rx_data, rx_exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [DATA_W-1:0] d);
    int guard = 0;
    while (!bus_if.tx_ready && guard < 100) begin
      tick(1);
      guard++;
    end
    check_value("tx_ready_before_write", bus_if.tx_ready, 1);
    bus_if.tx_data  = d;
    bus_if.tx_valid = 1'b1;
    tick(1);
    bus_if.tx_valid = 1'b0;
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_release();
    tick(4);
    cs_n = 1'b1;
  endtask

  // Master side of one frame: drive mosi on sclk fall, capture miso on rise.
  task automatic spi_frame(input logic [DATA_W-1:0] tx_word, input int nbits,
                           output logic [DATA_W-1:0] rx_word);
    int lat;
    rx_word = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = tx_word[bit_idx(i)];
      tick(HALF);
      sclk = 1'b1;
      rx_word[bit_idx(i)] = miso;
      if (i == DATA_W - 1) begin
        lat = 0;
        while (!bus_if.rx_valid && lat < 20) begin
          tick(1);
          lat++;
        end
        check_value("rx_valid_latency", lat, 3);
        if (lat < HALF) tick(HALF - lat);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic do_frame(input logic [DATA_W-1:0] mosi_word,
                          input logic [DATA_W-1:0] miso_exp, input string tag);
    logic [DATA_W-1:0] got;
    rx_exp_q.push_back(mosi_word);
    spi_frame(mosi_word, DATA_W, got);
    check_value(tag, got, miso_exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    int r0;
    logic [DATA_W-1:0] dummy;
    bus_if.tx_data  = '0;
    bus_if.tx_valid = 1'b0;
    tick(3);
    check_value("rst_miso", miso, 0);
    check_value("rst_miso_oe", miso_oe, 0);
    check_value("rst_tx_ready", bus_if.tx_ready, 1);
    check_value("rst_rx_data", bus_if.rx_data, 0);
    check_value("rst_rx_valid", bus_if.rx_valid, 0);
    check_value("rst_underrun", tx_underrun, 0);
    check_value("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick(5);

    // Basic frame with preloaded TX word.
    tx_write(8'hA5);
    check_value("t1_tx_ready_full", bus_if.tx_ready, 0);
    u0 = n_underrun;
    cs_assert();
    check_value("t1_tx_ready_start", bus_if.tx_ready, 1);
    check_value("t1_busy", busy, 1);
    check_value("t1_miso_oe", miso_oe, 1);
    do_frame(8'h3C, 8'hA5, "t1_miso_word");
    cs_release();
    tick(6);
    check_value("t1_busy_idle", busy, 0);
    check_value("t1_miso_oe_idle", miso_oe, 0);
    check_value("t1_underrun", n_underrun - u0, 0);
    check_value("t1_rx_data", bus_if.rx_data, 8'h3C);

    // Underrun: no TX word written.
    u0 = n_underrun;
    cs_assert();
    do_frame(8'hFF, 8'h00, "t2_miso_word");
    cs_release();
    tick(6);
    check_value("t2_underrun", n_underrun - u0, 1);
    check_value("t2_rx_data", bus_if.rx_data, 8'hFF);

    // Two back-to-back frames under one chip select.
    tx_write(8'h55);
    u0 = n_underrun;
    r0 = n_rxv;
    cs_assert();
    fork
      do_frame(8'h12, 8'h55, "t3_miso_word0");
      begin
        tick(30);
        tx_write(8'hAA);
      end
    join
    do_frame(8'h34, 8'hAA, "t3_miso_word1");
    cs_release();
    tick(6);
    check_value("t3_underrun", n_underrun - u0, 0);
    check_value("t3_rx_pulses", n_rxv - r0, 2);
    check_value("t3_rx_data", bus_if.rx_data, 8'h34);

    // Aborted frame after 5 bits.
    u0 = n_underrun;
    r0 = n_rxv;
    cs_assert();
    spi_frame(8'hE7, 5, dummy);
    cs_n = 1'b1;
    tick(3);
    check_value("t4_busy_drop", busy, 0);
    tick(6);
    check_value("t4_rx_pulses", n_rxv - r0, 0);
    check_value("t4_rx_kept", bus_if.rx_data, 8'h34);
    check_value("t4_underrun", n_underrun - u0, 1);
    tx_write(8'h3C);
    cs_assert();
    do_frame(8'h81, 8'h3C, "t4_miso_word");
    cs_release();
    tick(6);
    check_value("t4_rx_data", bus_if.rx_data, 8'h81);

    // Reset in the middle of a frame.
    cs_assert();
    tx_write(8'h42);
    spi_frame(8'hC3, 4, dummy);
    check_value("t5_busy_pre", busy, 1);
    check_value("t5_tx_ready_pre", bus_if.tx_ready, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_value("t5_miso", miso, 0);
    check_value("t5_miso_oe", miso_oe, 0);
    check_value("t5_tx_ready", bus_if.tx_ready, 1);
    check_value("t5_rx_data", bus_if.rx_data, 0);
    check_value("t5_rx_valid", bus_if.rx_valid, 0);
    check_value("t5_underrun", tx_underrun, 0);
    check_value("t5_busy", busy, 0);
    cs_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    tx_write(8'h99);
    cs_assert();
    do_frame(8'h7E, 8'h99, "t5_miso_word");
    cs_release();
    tick(6);
    check_value("t5_rx_after", bus_if.rx_data, 8'h7E);

    // Bit order: 0x80 gives a leading 1 only when MSB first.
    tx_write(8'h80);
    cs_assert();
`ifdef SPI_SLAVE_MSB_FIRST_EN
    check_value("t6_first_bit", miso, 1);
`else
    check_value("t6_first_bit", miso, 0);
`endif
    do_frame(8'h01, 8'h80, "t6_miso_word");
    cs_release();
    tick(6);
    check_value("t6_rx_data", bus_if.rx_data, 8'h01);

    tick(10);
    check_value("final_rx_drained", rx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
